// File: rtl/prf_writeback_arbiter_if.sv
// Bundle between the result producers / register file and the writeback arbiter.
// The slave modport is the arbiter; the master modport is the producer and
// register-file side.
interface prf_writeback_arbiter_if #(
  parameter int NUM_REQ   = 7,
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 32,
  parameter int PHY_W     = 8
);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*PHY_W-1:0]    req_phy;
  logic [NUM_REQ*DATA_W-1:0]   req_data;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_PORTS-1:0]        wr_en;
  logic [NUM_PORTS*PHY_W-1:0]  wr_phy;
  logic [NUM_PORTS*DATA_W-1:0] wr_data;

  modport master (
    output req_valid,
    output req_phy,
    output req_data,
    input  req_ready,
    input  wr_en,
    input  wr_phy,
    input  wr_data
  );

  modport slave (
    input  req_valid,
    input  req_phy,
    input  req_data,
    output req_ready,
    output wr_en,
    output wr_phy,
    output wr_data
  );

endinterface

// File: rtl/prf_writeback_arbiter.sv
// Physical register file writeback arbiter.
// Grants up to NUM_PORTS eligible producers per cycle in round-robin order,
// acknowledges x0 writes for free, registers the winning writes onto the
// register-file ports and counts overloaded cycles. A flush cancels all
// grants and clears the pending writes.
module prf_writeback_arbiter #(
  parameter int NUM_REQ   = 7,
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 32,
  parameter int PHY_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  prf_writeback_arbiter_if.slave bus,
  output logic [15:0]            o_conflict_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(NUM_REQ + 1);
  localparam logic [PTR_W:0]   NUM_REQ_W  = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] PORTS_W    = CNT_W'(NUM_PORTS);

  logic [NUM_REQ-1:0]   w_eligible;
  logic [CNT_W-1:0]     w_eligCnt;
  logic                 w_overload;
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_anyGrant;
  logic [NUM_PORTS-1:0] w_portValid;
  logic [PHY_W-1:0]     w_portPhy  [NUM_PORTS];
  logic [DATA_W-1:0]    w_portData [NUM_PORTS];
  logic [PTR_W-1:0]     w_lastIdx;
  logic [PTR_W-1:0]     w_nextPtr;
  logic [NUM_REQ-1:0]   w_ready;

  logic [PTR_W-1:0]     r_rrPtr;
  logic [NUM_PORTS-1:0] r_wrEn;
  logic [PHY_W-1:0]     r_wrPhy  [NUM_PORTS];
  logic [DATA_W-1:0]    r_wrData [NUM_PORTS];
  logic [15:0]          r_conflictCnt;

  // A request competes for a port only when it targets a real register (tag != 0)
  always_comb begin
    w_eligible = '0;
    w_eligCnt  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_eligible[i] = bus.req_valid[i] && (bus.req_phy[i*PHY_W +: PHY_W] != '0);
      if (w_eligible[i]) begin
        w_eligCnt = w_eligCnt + CNT_W'(1);
      end
    end
  end

  assign w_overload = (w_eligCnt > PORTS_W);

  // Round-robin scan from r_rrPtr; the k-th grant found goes to port k
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    int               cnt;
    w_grant     = '0;
    w_portValid = '0;
    w_lastIdx   = r_rrPtr;
    sum         = '0;
    idx         = '0;
    cnt         = 0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_portPhy[p]  = '0;
      w_portData[p] = '0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, r_rrPtr} + (PTR_W + 1)'(k);
      if (sum >= NUM_REQ_W) begin
        sum = sum - NUM_REQ_W;
      end
      idx = sum[PTR_W-1:0];
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!i_flush && (PTR_W'(i) == idx) && w_eligible[i] && (cnt < NUM_PORTS)) begin
          w_grant[i] = 1'b1;
          w_lastIdx  = idx;
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (p == cnt) begin
              w_portValid[p] = 1'b1;
              w_portPhy[p]   = bus.req_phy[i*PHY_W +: PHY_W];
              w_portData[p]  = bus.req_data[i*DATA_W +: DATA_W];
            end
          end
          cnt = cnt + 1;
        end
      end
    end
  end

  assign w_anyGrant = |w_grant;

  // Pointer advances just past the last winner so it loses priority next cycle
  always_comb begin
    w_nextPtr = '0;
    if (w_lastIdx != LAST_IDX) begin
      w_nextPtr = w_lastIdx + PTR_W'(1);
    end
  end

  // Granted producers and x0 writers are acknowledged unless a flush is active
  always_comb begin
    w_ready = '0;
    if (!i_flush) begin
      w_ready = w_grant | (bus.req_valid & ~w_eligible);
    end
  end

  assign bus.req_ready = w_ready;

  // Round-robin pointer: restarts at 0 on flush, holds when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr <= '0;
    end else if (i_flush) begin
      r_rrPtr <= '0;
    end else if (w_anyGrant) begin
      r_rrPtr <= w_nextPtr;
    end
  end

  // Write-port registers: enable follows the grant, tag/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrEn <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_wrPhy[p]  <= '0;
        r_wrData[p] <= '0;
      end
    end else begin
      r_wrEn <= w_portValid;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_portValid[p]) begin
          r_wrPhy[p]  <= w_portPhy[p];
          r_wrData[p] <= w_portData[p];
        end
      end
    end
  end

  // Saturating count of cycles where demand exceeded the write ports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflictCnt <= '0;
    end else if (!i_flush && w_overload && (r_conflictCnt != 16'hFFFF)) begin
      r_conflictCnt <= r_conflictCnt + 16'd1;
    end
  end

  assign bus.wr_en      = r_wrEn;
  assign o_conflict_cnt = r_conflictCnt;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : gPortOut
    assign bus.wr_phy[g*PHY_W +: PHY_W]    = r_wrPhy[g];
    assign bus.wr_data[g*DATA_W +: DATA_W] = r_wrData[g];
  end

endmodule

// File: tb/tb_prf_writeback_arbiter.sv
// Testbench for prf_writeback_arbiter: directed vectors with literal checks,
// plus a queue-free behavioural model compared against the DUT every cycle.
module tb_prf_writeback_arbiter;

  localparam int NUM_REQ   = 7;
  localparam int NUM_PORTS = 2;
  localparam int DATA_W    = 32;
  localparam int PHY_W     = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [6:0]  reqValid;
  logic [7:0]  reqPhy  [NUM_REQ];
  logic [31:0] reqData [NUM_REQ];
  logic [15:0] conflictCnt;

  int total   = 0;
  int bad     = 0;
  int printed = 0;

  // Model state: what the register-file ports and counters must hold
  int          mRr   = 0;
  int          mCnt  = 0;
  logic [1:0]  mWrEn = '0;
  logic [7:0]  mPhy  [NUM_PORTS] = '{default: '0};
  logic [31:0] mData [NUM_PORTS] = '{default: '0};
  int          mG0, mG1, mNg, mNe;

  prf_writeback_arbiter_if #(
    .NUM_REQ(NUM_REQ), .NUM_PORTS(NUM_PORTS), .DATA_W(DATA_W), .PHY_W(PHY_W)
  ) bus ();

  prf_writeback_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_PORTS(NUM_PORTS), .DATA_W(DATA_W), .PHY_W(PHY_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_flush        (flush),
    .bus            (bus.slave),
    .o_conflict_cnt (conflictCnt)
  );

  always #5 clk = ~clk;

  // Pack the per-producer stimulus arrays onto the interface buses
  always_comb begin
    bus.req_valid = reqValid;
    bus.req_phy   = '0;
    bus.req_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_phy[i*PHY_W +: PHY_W]    = reqPhy[i];
      bus.req_data[i*DATA_W +: DATA_W] = reqData[i];
    end
  end

  // Who wins this cycle: first two real-register requests walking up from mRr
  function automatic void modelGrants(output int g0, output int g1,
                                      output int ng, output int ne);
    int i;
    g0 = -1; g1 = -1; ng = 0; ne = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      i = (mRr + k) % NUM_REQ;
      if (reqValid[i] && reqPhy[i] != 8'h00) begin
        ne++;
        if (!flush && ng < NUM_PORTS) begin
          if (ng == 0) g0 = i; else g1 = i;
          ng++;
        end
      end
    end
  endfunction

  function automatic logic [6:0] modelReady();
    int g0, g1, ng, ne;
    logic [6:0] r;
    r = '0;
    modelGrants(g0, g1, ng, ne);
    if (!flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (reqValid[i] && reqPhy[i] == 8'h00) r[i] = 1'b1;
      end
      if (ng > 0) r[g0] = 1'b1;
      if (ng > 1) r[g1] = 1'b1;
    end
    return r;
  endfunction

  // Model clears immediately when reset asserts
  always @(negedge rst_n) begin
    mRr = 0; mCnt = 0; mWrEn = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      mPhy[p] = '0; mData[p] = '0;
    end
  end

  // Model advances on every rising edge outside reset
  always @(posedge clk) begin
    if (rst_n) begin
      modelGrants(mG0, mG1, mNg, mNe);
      if (flush) begin
        mWrEn = '0;
        mRr   = 0;
      end else begin
        mWrEn[0] = (mNg > 0);
        mWrEn[1] = (mNg > 1);
        if (mNg > 0) begin mPhy[0] = reqPhy[mG0]; mData[0] = reqData[mG0]; end
        if (mNg > 1) begin mPhy[1] = reqPhy[mG1]; mData[1] = reqData[mG1]; end
        if (mNg > 0) mRr = (((mNg == 1) ? mG0 : mG1) + 1) % NUM_REQ;
        if (mNe > NUM_PORTS && mCnt < 65535) mCnt++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      if (printed < 40) begin
        printed++;
        $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
      end
    end
  endtask

  // Every falling edge, the DUT must agree with the model
  always @(negedge clk) begin
    checkOutput("cyc_ready",  64'(bus.req_ready), 64'(modelReady()));
    checkOutput("cyc_wr_en",  64'(bus.wr_en),     64'(mWrEn));
    checkOutput("cyc_wr_phy", 64'(bus.wr_phy),    64'({mPhy[1], mPhy[0]}));
    checkOutput("cyc_wr_data", 64'(bus.wr_data),  {mData[1], mData[0]});
    checkOutput("cyc_conflict", 64'(conflictCnt), 64'(mCnt));
  end

  task automatic applyStimulus(input int idx, input logic v,
                               input logic [7:0] phy, input logic [31:0] data);
    reqValid[idx] = v;
    reqPhy[idx]   = phy;
    reqData[idx]  = data;
  endtask

  task automatic clearAll();
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
  endtask

  logic [6:0] maskTable [6] = '{7'b1011011, 7'b0000000, 7'b1100000,
                                7'b0101010, 7'b1111111, 7'b0010001};
  logic [6:0] zeroTable [6] = '{7'b0000010, 7'b0000000, 7'b0000000,
                                7'b0100000, 7'b0001001, 7'b0000000};

  initial begin
    $display("[TB] starting prf_writeback_arbiter test");
    rst_n = 1'b0;
    flush = 1'b0;
    clearAll();

    // Reset state
    nextCycle();
    nextCycle();
    checkOutput("reset_wr_en",   64'(bus.wr_en),   64'h0);
    checkOutput("reset_wr_phy",  64'(bus.wr_phy),  64'h0);
    checkOutput("reset_wr_data", 64'(bus.wr_data), 64'h0);
    checkOutput("reset_conflict", 64'(conflictCnt), 64'h0);
    checkOutput("reset_ready",   64'(bus.req_ready), 64'h0);
    rst_n = 1'b1;

    // Single request from reset
    applyStimulus(2, 1'b1, 8'h25, 32'hDEADBEEF);
    #1;
    checkOutput("single_ready", 64'(bus.req_ready), 64'(7'b0000100));
    nextCycle();
    applyStimulus(2, 1'b0, 8'h00, 32'h0);
    checkOutput("single_wr_en",   64'(bus.wr_en), 64'(2'b01));
    checkOutput("single_wr_phy0", 64'(bus.wr_phy[7:0]), 64'h25);
    checkOutput("single_wr_dat0", 64'(bus.wr_data[31:0]), 64'hDEADBEEF);
    nextCycle();
    checkOutput("single_idle_en", 64'(bus.wr_en), 64'h0);

    // x0 discard alongside a real write (pointer now at 3)
    applyStimulus(1, 1'b1, 8'h00, 32'h11111111);
    applyStimulus(4, 1'b1, 8'h40, 32'h44444444);
    #1;
    checkOutput("x0_ready", 64'(bus.req_ready), 64'(7'b0010010));
    nextCycle();
    clearAll();
    checkOutput("x0_wr_en",   64'(bus.wr_en), 64'(2'b01));
    checkOutput("x0_wr_phy0", 64'(bus.wr_phy[7:0]), 64'h40);

    // Mixed patterns checked by the model only
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        applyStimulus(i, maskTable[v][i], zeroTable[v][i] ? 8'h00 : 8'(8'h50 + v*8 + i),
                      32'hA0000000 + 32'(v*16 + i));
      end
      nextCycle();
    end
    applyStimulus(0, 1'b1, 8'h77, 32'h1);
    applyStimulus(3, 1'b1, 8'h77, 32'h2);
    nextCycle();
    clearAll();

    // Full contention from rr_ptr=0
    doReset();
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1'b1, 8'(8'h21 + i), 32'hC0DE0000 + 32'(i));
    #1;
    checkOutput("cont_ready_c1", 64'(bus.req_ready), 64'(7'b0000011));
    nextCycle();
    checkOutput("cont_phy_c1",   64'(bus.wr_phy), 64'h2221);
    checkOutput("cont_ready_c2", 64'(bus.req_ready), 64'(7'b0001100));
    nextCycle();
    checkOutput("cont_phy_c2",   64'(bus.wr_phy), 64'h2423);
    checkOutput("cont_ready_c3", 64'(bus.req_ready), 64'(7'b0110000));
    nextCycle();
    checkOutput("cont_phy_c3",   64'(bus.wr_phy), 64'h2625);
    checkOutput("cont_conflict3", 64'(conflictCnt), 64'd3);
    checkOutput("cont_ready_c4", 64'(bus.req_ready), 64'(7'b1000001));
    nextCycle();
    checkOutput("cont_phy_c4",   64'(bus.wr_phy), 64'h2127);
    checkOutput("cont_wr_en_c4", 64'(bus.wr_en), 64'(2'b11));
    clearAll();

    // Move the pointer to 5, then flush with requests held
    applyStimulus(4, 1'b1, 8'h44, 32'h4);
    nextCycle();
    clearAll();
    flush = 1'b1;
    applyStimulus(0, 1'b1, 8'h30, 32'h30);
    applyStimulus(5, 1'b1, 8'h35, 32'h35);
    applyStimulus(6, 1'b1, 8'h36, 32'h36);
    #1;
    checkOutput("flush_ready", 64'(bus.req_ready), 64'h0);
    nextCycle();
    checkOutput("flush_wr_en",    64'(bus.wr_en), 64'h0);
    checkOutput("flush_conflict", 64'(conflictCnt), 64'd4);
    flush = 1'b0;
    #1;
    checkOutput("postflush_ready", 64'(bus.req_ready), 64'(7'b0100001));
    nextCycle();
    checkOutput("postflush_phy", 64'(bus.wr_phy), 64'h3530);
    nextCycle();
    clearAll();

    // Asynchronous reset while both ports are writing
    applyStimulus(1, 1'b1, 8'h51, 32'h51515151);
    applyStimulus(2, 1'b1, 8'h52, 32'h52525252);
    nextCycle();
    clearAll();
    checkOutput("pre_areset_en", 64'(bus.wr_en), 64'(2'b11));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_wr_en",   64'(bus.wr_en), 64'h0);
    checkOutput("areset_wr_phy",  64'(bus.wr_phy), 64'h0);
    checkOutput("areset_wr_data", 64'(bus.wr_data), 64'h0);
    #3;
    rst_n = 1'b1;
    applyStimulus(3, 1'b1, 8'h63, 32'h63);
    applyStimulus(6, 1'b1, 8'h66, 32'h66);
    applyStimulus(0, 1'b1, 8'h60, 32'h60);
    nextCycle();
    checkOutput("release_phy", 64'(bus.wr_phy), 64'h6360);
    clearAll();

    // Counter saturation
    doReset();
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1'b1, 8'(8'h71 + i), 32'(i));
    repeat (65540) nextCycle();
    checkOutput("sat_conflict", 64'(conflictCnt), 64'hFFFF);
    clearAll();
    nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
